// File: rtl/fifo_s18_s36.sv
// fifo_s18_s36: synchronous 2:1 width-packing FIFO.
// Accepts 18-bit halfwords (16 data + 2 parity) and delivers 36-bit words
// (32 data + 4 parity), with the first halfword written landing in the low
// half. The storage has the 1024x18 / 512x36 geometry of an S18/S36
// dual-port block RAM, and the read port is registered with one cycle of
// latency. All flags are registered from the next-state halfword count.
module fifo_s18_s36 #(
  parameter logic [10:0] ALMOST_FULL_OFFSET  = 11'd16,
  parameter logic [9:0]  ALMOST_EMPTY_OFFSET = 10'd4,
  parameter logic [35:0] SRVAL               = 36'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DI,
  input  logic [1:0]  DIP,
  input  logic        WREN,
  output logic        FULL,
  output logic        ALMOST_FULL,
  output logic        WRERR,
  output logic [31:0] DO,
  output logic [3:0]  DOP,
  input  logic        RDEN,
  output logic        EMPTY,
  output logic        ALMOST_EMPTY,
  output logic        RDERR,
  output logic [10:0] HALFCOUNT
);

  localparam logic [10:0] DEPTH_HW = 11'd1024;

  // The two halfword lanes of each 36-bit word are kept in separate banks.
  // Even halfword addresses go to the low bank and odd addresses to the
  // high bank.
  logic [17:0] mem_lo [0:511];
  logic [17:0] mem_hi [0:511];

  logic [10:0] wptr;
  logic [9:0]  rptr;
  logic [35:0] dout;

  logic        wacc;
  logic        racc;
  logic [10:0] cnt_next;
  logic        full_next;
  logic        empty_next;
  logic        afull_next;
  logic        aempty_next;

  // Acceptance and the next-state count, based on the flags registered before the edge.
  always_comb begin
    // NOTE: every signal gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    wacc        = WREN & ~FULL & ~RST;
    racc        = RDEN & ~EMPTY & ~RST;
    cnt_next    = HALFCOUNT + {10'd0, wacc} - {9'd0, racc, 1'b0};
    full_next   = (cnt_next == DEPTH_HW);
    empty_next  = (cnt_next < 11'd2);
    afull_next  = ((DEPTH_HW - cnt_next) <= ALMOST_FULL_OFFSET);
    aempty_next = (cnt_next[10:1] <= ALMOST_EMPTY_OFFSET);
  end

  // Storage banks: halfword write port, plus a registered 36-bit read port
  // that is loaded with SRVAL on reset.
  always_ff @(posedge CLK) begin
    // NOTE: the storage arrays have no reset. Stale contents are unreachable
    // because the pointers restart, and a RAM that has no reset maps onto
    // block RAM.
    if (wacc) begin
      if (wptr[0]) mem_hi[wptr[9:1]] <= {DIP, DI};
      else         mem_lo[wptr[9:1]] <= {DIP, DI};
    end
    if (RST) begin
      dout <= SRVAL;
    end else if (racc) begin
      dout <= {mem_hi[rptr[8:0]][17:16], mem_lo[rptr[8:0]][17:16],
               mem_hi[rptr[8:0]][15:0],  mem_lo[rptr[8:0]][15:0]};
    end
  end

  // Pointers, count, flags and error pulses.
  always_ff @(posedge CLK) begin
    // NOTE: all state is updated with non-blocking assignments, so every
    // right-hand side sees the values from before this edge.
    if (RST) begin
      wptr         <= '0;
      rptr         <= '0;
      HALFCOUNT    <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      WRERR        <= 1'b0;
      RDERR        <= 1'b0;
    end else begin
      if (wacc) wptr <= wptr + 11'd1;
      if (racc) rptr <= rptr + 10'd1;
      HALFCOUNT    <= cnt_next;
      FULL         <= full_next;
      EMPTY        <= empty_next;
      ALMOST_FULL  <= afull_next;
      ALMOST_EMPTY <= aempty_next;
      WRERR        <= WREN & FULL;
      RDERR        <= RDEN & EMPTY;
    end
  end

  assign DO  = dout[31:0];
  assign DOP = dout[35:32];

endmodule

// File: tb/tb_fifo_s18_s36.sv
// Self-checking bench for fifo_s18_s36.
// A queue-based scoreboard is checked on every cycle. Table-driven vectors
// cover the basic pack/read and odd-halfword cases, and hand-written
// sequences cover fill, drain, pointer wrap, simultaneous read and write,
// and reset in the middle of operation.
module tb_fifo_s18_s36;

  localparam logic [35:0] SRVAL = 36'h0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DI = '0;
  logic [1:0]  DIP = '0;
  logic        WREN = 1'b0;
  logic        RDEN = 1'b0;
  logic        FULL, ALMOST_FULL, WRERR, EMPTY, ALMOST_EMPTY, RDERR;
  logic [31:0] DO;
  logic [3:0]  DOP;
  logic [10:0] HALFCOUNT;

  fifo_s18_s36 #(
    .ALMOST_FULL_OFFSET (11'd16),
    .ALMOST_EMPTY_OFFSET(10'd4),
    .SRVAL              (SRVAL)
  ) dut (
    .CLK(CLK), .RST(RST), .DI(DI), .DIP(DIP), .WREN(WREN),
    .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .WRERR(WRERR),
    .DO(DO), .DOP(DOP), .RDEN(RDEN), .EMPTY(EMPTY),
    .ALMOST_EMPTY(ALMOST_EMPTY), .RDERR(RDERR), .HALFCOUNT(HALFCOUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard state.
  logic [35:0] exp_q[$];
  logic [17:0] m_lo;
  logic        m_wpar;
  int          m_cnt;
  logic [35:0] m_do;
  logic        m_wrerr;
  logic        m_rderr;

  typedef struct {
    logic        w;
    logic [15:0] d;
    logic [1:0]  p;
    logic        r;
    logic [10:0] cnt;
    logic        empty;
    logic        rderr;
    logic [35:0] dout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".halfcount"}, 36'(HALFCOUNT), 36'(m_cnt));
    check({tag, ".empty"}, 36'(EMPTY), 36'(m_cnt < 2));
    check({tag, ".full"}, 36'(FULL), 36'(m_cnt == 1024));
    check({tag, ".almost_empty"}, 36'(ALMOST_EMPTY), 36'((m_cnt / 2) <= 4));
    check({tag, ".almost_full"}, 36'(ALMOST_FULL), 36'((1024 - m_cnt) <= 16));
    check({tag, ".wrerr"}, 36'(WRERR), 36'(m_wrerr));
    check({tag, ".rderr"}, 36'(RDERR), 36'(m_rderr));
    check({tag, ".data"}, {DOP, DO}, m_do);
  endtask

  task automatic apply_reset(input logic w, input logic r);
    RST = 1'b1; WREN = w; RDEN = r; DI = 16'hDEAD; DIP = 2'b11;
    @(posedge CLK); #1;
    RST = 1'b0; WREN = 1'b0; RDEN = 1'b0;
    exp_q.delete();
    m_lo = '0; m_wpar = 1'b0; m_cnt = 0; m_do = SRVAL;
    m_wrerr = 1'b0; m_rderr = 1'b0;
    check_all("reset");
  endtask

  // Drive one cycle, advance the scoreboard, then compare every output.
  task automatic cycle(input logic w, input logic [15:0] d, input logic [1:0] p, input logic r);
    bit wacc, racc;
    logic [17:0] hw;
    WREN = w; DI = d; DIP = p; RDEN = r;
    wacc = w && (m_cnt != 1024);
    racc = r && (m_cnt >= 2);
    @(posedge CLK); #1;
    m_wrerr = w && !wacc;
    m_rderr = r && !racc;
    if (racc) begin
      m_do = exp_q.pop_front();
      m_cnt -= 2;
    end
    if (wacc) begin
      hw = {p, d};
      if (!m_wpar) m_lo = hw;
      else exp_q.push_back({hw[17:16], m_lo[17:16], hw[15:0], m_lo[15:0]});
      m_wpar = ~m_wpar;
      m_cnt++;
    end
    check_all("cyc");
    WREN = 1'b0; RDEN = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h1111, 2'b01, 1'b0, 11'd1, 1'b1, 1'b0, 36'h0};
    vecs[1] = '{1'b1, 16'h2222, 2'b10, 1'b0, 11'd2, 1'b0, 1'b0, 36'h0};
    vecs[2] = '{1'b0, 16'h0,    2'b00, 1'b1, 11'd0, 1'b1, 1'b0, 36'h9_2222_1111};
    vecs[3] = '{1'b0, 16'h0,    2'b00, 1'b0, 11'd0, 1'b1, 1'b0, 36'h9_2222_1111};
    vecs[4] = '{1'b1, 16'h3333, 2'b11, 1'b0, 11'd1, 1'b1, 1'b0, 36'h0};
    vecs[5] = '{1'b0, 16'h0,    2'b00, 1'b1, 11'd1, 1'b1, 1'b1, 36'h0};
    vecs[6] = '{1'b0, 16'h0,    2'b00, 1'b0, 11'd1, 1'b1, 1'b0, 36'h0};

    apply_reset(1'b0, 1'b0);

    // Basic pack/read, and the odd-halfword-only case (a reset comes before vector 4).
    for (int i = 0; i < 7; i++) begin
      if (i == 4) apply_reset(1'b0, 1'b0);
      cycle(vecs[i].w, vecs[i].d, vecs[i].p, vecs[i].r);
      check($sformatf("vec%0d.halfcount", i), 36'(HALFCOUNT), 36'(vecs[i].cnt));
      check($sformatf("vec%0d.empty", i), 36'(EMPTY), 36'(vecs[i].empty));
      check($sformatf("vec%0d.rderr", i), 36'(RDERR), 36'(vecs[i].rderr));
      check($sformatf("vec%0d.data", i), {DOP, DO}, vecs[i].dout);
    end

    // Fill to FULL with value = index, checking the almost-flag thresholds.
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      cycle(1'b1, 16'(i), 2'(i), 1'b0);
      if (i == 8)    check("ae_at_9", 36'(ALMOST_EMPTY), 36'd1);
      if (i == 9)    check("ae_at_10", 36'(ALMOST_EMPTY), 36'd0);
      if (i == 1006) check("af_at_1007", 36'(ALMOST_FULL), 36'd0);
      if (i == 1007) check("af_at_1008", 36'(ALMOST_FULL), 36'd1);
    end
    check("full_set", 36'(FULL), 36'd1);
    check("full_count", 36'(HALFCOUNT), 36'd1024);
    cycle(1'b1, 16'hFFFF, 2'b11, 1'b0);
    check("overflow_wrerr", 36'(WRERR), 36'd1);
    check("overflow_count", 36'(HALFCOUNT), 36'd1024);
    cycle(1'b0, 16'h0, 2'b00, 1'b0);
    check("wrerr_one_cycle", 36'(WRERR), 36'd0);

    // Drain. The first read is paired with a write that FULL rejects.
    for (int k = 0; k < 512; k++) begin
      cycle(k == 0, 16'h5A5A, 2'b00, 1'b1);
      check($sformatf("drain%0d", k), {DOP, DO},
            {2'(2*k+1), 2'(2*k), 16'(2*k+1), 16'(2*k)});
    end
    check("drain_empty", 36'(EMPTY), 36'd1);

    // Wrap the pointers: 600 writes with reads on alternate cycles, then drain.
    for (int i = 0; i < 600; i++)
      cycle(1'b1, 16'($urandom), 2'($urandom), i[0]);
    while (m_cnt >= 2) cycle(1'b0, 16'h0, 2'b00, 1'b1);
    check("wrap_empty", 36'(EMPTY), 36'd1);
    check("wrap_odd_left", 36'(HALFCOUNT), 36'd0);

    // Simultaneous read and write starting from a count of 6.
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'h6000 + 16'(i), 2'(i), 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 16'h7000 + 16'(k), 2'(k), 1'b1);
      check($sformatf("rw_count%0d", k), 36'(HALFCOUNT), 36'(5 - k));
    end
    while (m_cnt >= 2) cycle(1'b0, 16'h0, 2'b00, 1'b1);

    // Reset in the middle of operation, with requests asserted during the reset cycle.
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h8000 + 16'(i), 2'b01, 1'b0);
    apply_reset(1'b1, 1'b1);
    cycle(1'b1, 16'hAAAA, 2'b00, 1'b0);
    cycle(1'b1, 16'hBBBB, 2'b01, 1'b0);
    cycle(1'b0, 16'h0, 2'b00, 1'b1);
    check("post_reset_do", 36'(DO), 36'(32'hBBBB_AAAA));
    check("post_reset_dop", 36'(DOP), 36'(4'b0100));
    check("post_reset_empty", 36'(EMPTY), 36'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
